// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder slice.
//   - state_t       : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - DEFAULT_WIDTH : default operand/sum width
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add1.sv
// add1
//   Existing 1-bit full adder cell. Purely combinational.
//   Ports:
//     a, b  : addend bits
//     cin   : carry in
//     sum   : a ^ b ^ cin
//     cout  : majority(a, b, cin)
module add1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder built around a single add1 full-adder cell.
//   Operands are accepted in IDLE, added one bit per cycle LSB first in RUN
//   (carry held in a flop between bits), and the result is presented in DONE
//   until the consumer takes it.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//     a, b, cin           : operands and carry-in for bit 0
//     out_valid/out_ready : result handshake (out_valid high only in DONE)
//     sum, cout           : registered result, held until the next DONE
//     ovf                 : signed overflow, only when SERIAL_ADDER_OVF_EN
//                           is defined
//   Build option: `define SERIAL_ADDER_OVF_EN adds the ovf output and its flop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] sum_sh_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_reg;
`endif

  logic             bit_sum;
  logic             bit_cout;
  logic [WIDTH-1:0] sum_sh_next;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    inc_carry;

  add1 u_add1 (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .cin  (carry_reg),
    .sum  (bit_sum),
    .cout (bit_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at index 0.
  assign sum_sh_next = {bit_sum, sum_sh_reg[WIDTH-1:1]};

  // Counter increment as a half-adder ripple so all '+' arithmetic stays out
  // of this block.
  assign inc_carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < CW; gi++) begin : g_cnt_inc
      assign cnt_next[gi] = cnt_reg[gi] ^ inc_carry[gi];
      if (gi < CW - 1) begin : g_chain
        assign inc_carry[gi+1] = inc_carry[gi] & cnt_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      sum_sh_reg    <= '0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      carry_reg     <= 1'b0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_sh_reg     <= a;
            b_sh_reg     <= b;
            carry_reg    <= cin;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          sum_sh_reg <= sum_sh_next;
          carry_reg  <= bit_cout;
          cnt_reg    <= cnt_next;
          if (cnt_reg == CNT_LAST) begin
            // Last bit: publish the result so sum/cout only change here.
            sum_reg       <= sum_sh_next;
            cout_reg      <= bit_cout;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_reg is the carry into the MSB during this cycle.
            ovf_reg       <= carry_reg ^ bit_cout;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed and random checks of serial_adder (WIDTH=8) with a scoreboard
//   queue of expected results. Build with SERIAL_ADDER_OVF_EN to also check ovf.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int sent     = 0;
  int received = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive an operand pair, wait (bounded) for acceptance, push expectation.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    int n;
    logic [W:0] full;
    exp_t e;
    n = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_wait", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    e.s = full[W-1:0];
    e.c = full[W];
    e.o = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
    q.push_back(e);
    sent++;
    $display("send a=%02h b=%02h cin=%0d expect sum=%02h cout=%0d", av, bv, cv, e.s, e.c);
  endtask

  // Called right after send: check latency, stall `stall` cycles (optionally
  // poking in_valid), then consume and compare with the scoreboard head.
  task automatic recv(input int stall, input bit poke);
    int lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(W));
    if (!out_valid) return;
    chk("queue_nonempty", 32'(q.size() > 0), 32'd1);
    if (q.size() == 0) return;
    e = q[0];
    for (int i = 0; i < stall; i++) begin
      chk("stall_sum", 32'(sum), 32'(e.s));
      chk("stall_cout", 32'(cout), 32'(e.c));
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (poke && i == 1) begin
        in_valid = 1'b1;
        a = 8'h01;
        b = 8'h00;
        cin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    chk("sum", 32'(sum), 32'(e.s));
    chk("cout", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", 32'(ovf), 32'(e.o));
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    void'(q.pop_front());
    received++;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("held_sum", 32'(sum), 32'(e.s));
    $display("recv sum=%02h cout=%0d latency=%0d stall=%0d", sum, cout, lat, stall);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic and wrap-around cases.
    send(8'h5A, 8'h33, 1'b0); recv(0, 1'b0);
    send(8'hFF, 8'h01, 1'b0); recv(0, 1'b0);
    send(8'hFF, 8'hFF, 1'b1); recv(0, 1'b0);

    // Long stall in DONE with an in_valid pulse that must be ignored.
    send(8'h12, 8'h34, 1'b0); recv(5, 1'b1);
    send(8'h01, 8'h01, 1'b0); recv(0, 1'b0);

    // Reset on the third RUN cycle drops the transaction.
    send(8'h44, 8'h55, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_sum", 32'(sum), 32'd0);
    chk("midrun_rst_cout", 32'(cout), 32'd0);
    void'(q.pop_back());
    sent--;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(8'h10, 8'h20, 1'b0); recv(0, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
    send(8'h7F, 8'h01, 1'b0); recv(0, 1'b0);
    send(8'h80, 8'h80, 1'b0); recv(0, 1'b0);
`endif

    // Random back-to-back traffic with random consumer stalls.
    for (int t = 0; t < 1000; t++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom));
      recv(int'($urandom_range(0, 3)), 1'b0);
    end

    chk("count_match", 32'(received), 32'(sent));
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
